// File: rtl/pe_pkg.sv
// pe_pkg
// Shared types and helpers for the configurable processing element.
//   pe_mode_e : runtime dataflow mode (weight-stationary / output-stationary)
//   sat_max   : largest value a signed word of the given width can hold
//   sat_min   : smallest value a signed word of the given width can hold
package pe_pkg;

  typedef enum logic {
    PE_MODE_WS = 1'b0,
    PE_MODE_OS = 1'b1
  } pe_mode_e;

  function automatic longint sat_max(input int width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/pe_sat_add.sv
// pe_sat_add
// Combinational signed adder with optional saturation.
//   i_a, i_b   : signed ACC_WIDTH operands
//   o_sum      : clamped (SATURATE=1) or wrapped (SATURATE=0) sum
//   o_overflow : the true sum did not fit in ACC_WIDTH bits
module pe_sat_add
  import pe_pkg::*;
#(
  parameter int ACC_WIDTH = 20,
  parameter bit SATURATE  = 1'b1
) (
  input  logic signed [ACC_WIDTH-1:0] i_a,
  input  logic signed [ACC_WIDTH-1:0] i_b,
  output logic signed [ACC_WIDTH-1:0] o_sum,
  output logic                        o_overflow
);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));

  logic [ACC_WIDTH:0] w_wide;

  // One extra bit holds the exact sum; the two top bits disagree exactly
  // when the result left the representable range.
  assign w_wide     = {i_a[ACC_WIDTH-1], i_a} + {i_b[ACC_WIDTH-1], i_b};
  assign o_overflow = w_wide[ACC_WIDTH] ^ w_wide[ACC_WIDTH-1];

  // The extra top bit is the true sign, so it picks the clamp direction.
  always_comb begin
    o_sum = w_wide[ACC_WIDTH-1:0];
    if (SATURATE && o_overflow) begin
      o_sum = w_wide[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/configurable_pe.sv
// configurable_pe
// Multiply-accumulate processing element for a systolic array. Data moves
// west to east; partial sums and weights move north to south.
//   clk, rst_n       : clock, asynchronous active-low reset
//   mode             : 0 = weight-stationary, 1 = output-stationary
//   data_in/_valid   : activation from west, registered to data_out (east)
//   psum_in/_valid   : partial sum from north
//   psum_out/_valid  : partial sum (WS), forwarded or drained result (OS)
//   weight_in        : weight chain input; weight_out is the shadow weight
//   weight_load/swap : write shadow weight / promote shadow to active
//   acc_clear        : OS: zero the accumulator and overflow flag
//   acc_drain        : OS: emit the accumulator on psum_out and restart
//   overflow         : sticky flag for any out-of-range addition
module configurable_pe
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mode,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         data_valid_in,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         data_valid_out,
  input  logic signed [ACC_WIDTH-1:0]  psum_in,
  input  logic                         psum_valid_in,
  output logic signed [ACC_WIDTH-1:0]  psum_out,
  output logic                         psum_valid_out,
  input  logic signed [DATA_WIDTH-1:0] weight_in,
  input  logic                         weight_load,
  input  logic                         weight_swap,
  output logic signed [DATA_WIDTH-1:0] weight_out,
  input  logic                         acc_clear,
  input  logic                         acc_drain,
  output logic                         overflow
);

  // A full product plus at least one guard bit must fit the accumulator.
  if (ACC_WIDTH < 2 * DATA_WIDTH + 1) begin : g_width_check
    $error("configurable_pe: ACC_WIDTH must be at least 2*DATA_WIDTH+1");
  end

  pe_mode_e w_mode;

  logic signed [DATA_WIDTH-1:0]   r_w_shadow;
  logic signed [DATA_WIDTH-1:0]   r_w_active;
  logic signed [DATA_WIDTH-1:0]   r_data_out;
  logic                           r_data_valid_out;
  logic signed [ACC_WIDTH-1:0]    r_psum_out;
  logic                           r_psum_valid_out;
  logic signed [ACC_WIDTH-1:0]    r_acc;
  logic                           r_overflow;

  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0]    w_prod_ext;
  logic signed [ACC_WIDTH-1:0]    w_base;
  logic signed [ACC_WIDTH-1:0]    w_add_a;
  logic signed [ACC_WIDTH-1:0]    w_add_b;
  logic signed [ACC_WIDTH-1:0]    w_sum;
  logic                           w_add_ovf;
  logic                           w_ovf_event;

  assign w_mode = pe_mode_e'(mode);

  // The multiply always uses the currently active weight, so a swap in the
  // same cycle only affects the following MACs.
  assign w_prod     = data_in * r_w_active;
  assign w_prod_ext = {{(ACC_WIDTH - 2 * DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};

  // One shared adder: WS adds onto the incoming partial sum, OS onto the
  // (optionally cleared) local accumulator.
  assign w_base  = acc_clear ? '0 : r_acc;
  assign w_add_a = (w_mode == PE_MODE_WS) ? psum_in : w_base;
  assign w_add_b = data_valid_in ? w_prod_ext : '0;

  pe_sat_add #(
    .ACC_WIDTH (ACC_WIDTH),
    .SATURATE  (SATURATE)
  ) u_add (
    .i_a        (w_add_a),
    .i_b        (w_add_b),
    .o_sum      (w_sum),
    .o_overflow (w_add_ovf)
  );

  // Adding zero can never overflow, so only a real MAC raises the flag.
  assign w_ovf_event = data_valid_in & w_add_ovf;

  // Weight double buffer: the shadow shifts down the column while the active
  // copy keeps serving MACs until a swap promotes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w_shadow <= '0;
      r_w_active <= '0;
    end else begin
      if (weight_swap) r_w_active <= r_w_shadow;
      if (weight_load) r_w_shadow <= weight_in;
    end
  end

  // Activation pipeline: data_out keeps its last valid value between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out       <= '0;
      r_data_valid_out <= 1'b0;
    end else begin
      r_data_valid_out <= data_valid_in;
      if (data_valid_in) r_data_out <= data_in;
    end
  end

  // Clear first, then let an overflow in the same cycle set the flag again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= (acc_clear ? 1'b0 : r_overflow) | w_ovf_event;
    end
  end

  // Partial-sum path and accumulator. In OS mode a local drain takes
  // priority over forwarding an upstream result; the controller staggers
  // drains diagonally so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psum_out       <= '0;
      r_psum_valid_out <= 1'b0;
      r_acc            <= '0;
    end else begin
      case (w_mode)
        PE_MODE_WS: begin
          if (data_valid_in) begin
            r_psum_out       <= w_sum;
            r_psum_valid_out <= 1'b1;
          end else begin
            r_psum_valid_out <= 1'b0;
          end
        end
        PE_MODE_OS: begin
          if (acc_drain) begin
            r_psum_out       <= w_sum;
            r_psum_valid_out <= 1'b1;
            r_acc            <= '0;
          end else begin
            r_acc <= w_sum;
            if (psum_valid_in) begin
              r_psum_out       <= psum_in;
              r_psum_valid_out <= 1'b1;
            end else begin
              r_psum_valid_out <= 1'b0;
            end
          end
        end
        default: begin
          r_psum_valid_out <= 1'b0;
        end
      endcase
    end
  end

  assign data_out       = r_data_out;
  assign data_valid_out = r_data_valid_out;
  assign psum_out       = r_psum_out;
  assign psum_valid_out = r_psum_valid_out;
  assign weight_out     = r_w_shadow;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_configurable_pe.sv
// tb_configurable_pe
// Drives a saturating and a wrapping configurable_pe with identical inputs.
// An integer reference model predicts every cycle's outputs into a
// scoreboard queue; a monitor pops and compares after each rising edge.
module tb_configurable_pe;

  localparam int DW = 8;
  localparam int AW = 20;
  localparam longint ACC_MAX = (longint'(1) <<< (AW - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (AW - 1));
  localparam longint ACC_SPAN = longint'(1) <<< AW;

  logic clk = 1'b0;
  logic rst_n;
  logic mode;
  logic signed [DW-1:0] data_in;
  logic data_valid_in;
  logic signed [AW-1:0] psum_in;
  logic psum_valid_in;
  logic signed [DW-1:0] weight_in;
  logic weight_load, weight_swap, acc_clear, acc_drain;

  logic signed [DW-1:0] dout_s, dout_w, wout_s, wout_w;
  logic dv_s, dv_w, pv_s, pv_w, ovf_s, ovf_w;
  logic signed [AW-1:0] psum_s, psum_w;

  always #5 clk = ~clk;

  configurable_pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .data_in(data_in), .data_valid_in(data_valid_in),
    .data_out(dout_s), .data_valid_out(dv_s),
    .psum_in(psum_in), .psum_valid_in(psum_valid_in),
    .psum_out(psum_s), .psum_valid_out(pv_s),
    .weight_in(weight_in), .weight_load(weight_load), .weight_swap(weight_swap),
    .weight_out(wout_s), .acc_clear(acc_clear), .acc_drain(acc_drain),
    .overflow(ovf_s)
  );

  configurable_pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .mode(mode),
    .data_in(data_in), .data_valid_in(data_valid_in),
    .data_out(dout_w), .data_valid_out(dv_w),
    .psum_in(psum_in), .psum_valid_in(psum_valid_in),
    .psum_out(psum_w), .psum_valid_out(pv_w),
    .weight_in(weight_in), .weight_load(weight_load), .weight_swap(weight_swap),
    .weight_out(wout_w), .acc_clear(acc_clear), .acc_drain(acc_drain),
    .overflow(ovf_w)
  );

  typedef struct {
    bit     dv;
    longint dout;
    longint wout;
    bit     pv0, pv1;
    longint psum0, psum1;
    bit     ovf0, ovf1;
  } exp_t;

  exp_t sb[$];

  int testsRun = 0;
  int testsFailed = 0;

  // Reference state: index 0 = saturating instance, 1 = wrapping instance
  longint mAcc[2];
  longint mPsum[2];
  bit     mPv[2];
  bit     mOvf[2];
  longint mDout, mShadow, mActive;
  bit     mDv;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reduce an exact sum to the accumulator range, clamping or wrapping.
  function automatic longint fitAcc(input longint x, input bit sat, output bit ovf);
    longint m;
    ovf = (x > ACC_MAX) || (x < ACC_MIN);
    if (!ovf) return x;
    if (sat) return (x > ACC_MAX) ? ACC_MAX : ACC_MIN;
    m = x % ACC_SPAN;
    if (m > ACC_MAX) m -= ACC_SPAN;
    if (m < ACC_MIN) m += ACC_SPAN;
    return m;
  endfunction

  task automatic resetModel();
    for (int k = 0; k < 2; k++) begin
      mAcc[k] = 0; mPsum[k] = 0; mPv[k] = 0; mOvf[k] = 0;
    end
    mDout = 0; mShadow = 0; mActive = 0; mDv = 0;
  endtask

  task automatic applyStimulus(input bit md, input int din, input bit dvin,
                               input longint pin, input bit pvin, input int win,
                               input bit ld, input bit sw, input bit clr, input bit drn);
    longint p, r, base;
    bit o;
    exp_t e;
    @(negedge clk);
    mode = md; data_in = DW'(din); data_valid_in = dvin;
    psum_in = AW'(pin); psum_valid_in = pvin; weight_in = DW'(win);
    weight_load = ld; weight_swap = sw; acc_clear = clr; acc_drain = drn;

    p = longint'(din) * mActive;
    for (int k = 0; k < 2; k++) begin
      if (!md) begin
        r = fitAcc(pin + p, (k == 0), o);
        mOvf[k] = (clr ? 1'b0 : mOvf[k]) | (dvin & o);
        if (dvin) begin mPsum[k] = r; mPv[k] = 1; end
        else mPv[k] = 0;
      end else begin
        base = clr ? 0 : mAcc[k];
        r = fitAcc(base + (dvin ? p : 0), (k == 0), o);
        mOvf[k] = (clr ? 1'b0 : mOvf[k]) | o;
        if (drn) begin mPsum[k] = r; mPv[k] = 1; mAcc[k] = 0; end
        else begin
          mAcc[k] = r;
          if (pvin) begin mPsum[k] = pin; mPv[k] = 1; end
          else mPv[k] = 0;
        end
      end
    end
    if (sw) mActive = mShadow;
    if (ld) mShadow = win;
    mDv = dvin;
    if (dvin) mDout = din;

    e.dv = mDv; e.dout = mDout; e.wout = mShadow;
    e.pv0 = mPv[0]; e.pv1 = mPv[1]; e.psum0 = mPsum[0]; e.psum1 = mPsum[1];
    e.ovf0 = mOvf[0]; e.ovf1 = mOvf[1];
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit md);
    applyStimulus(md, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: one expected record per driven cycle, checked after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("sb_data_valid", longint'(dv_s), longint'(e.dv));
        checkOutput("sb_data_out", longint'(dout_s), e.dout);
        checkOutput("sb_weight_out", longint'(wout_s), e.wout);
        checkOutput("sb_psum_valid_sat", longint'(pv_s), longint'(e.pv0));
        checkOutput("sb_psum_out_sat", longint'(psum_s), e.psum0);
        checkOutput("sb_overflow_sat", longint'(ovf_s), longint'(e.ovf0));
        checkOutput("sb_psum_valid_wrap", longint'(pv_w), longint'(e.pv1));
        checkOutput("sb_psum_out_wrap", longint'(psum_w), e.psum1);
        checkOutput("sb_overflow_wrap", longint'(ovf_w), longint'(e.ovf1));
        checkOutput("sb_data_out_wrap", longint'(dout_w), e.dout);
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_data_out"}, longint'(dout_s), 0);
    checkOutput({tag, "_data_valid"}, longint'(dv_s), 0);
    checkOutput({tag, "_psum_out"}, longint'(psum_s), 0);
    checkOutput({tag, "_psum_valid"}, longint'(pv_s), 0);
    checkOutput({tag, "_weight_out"}, longint'(wout_s), 0);
    checkOutput({tag, "_overflow"}, longint'(ovf_s), 0);
    checkOutput({tag, "_psum_out_wrap"}, longint'(psum_w), 0);
  endtask

  task automatic zeroInputs();
    mode = 0; data_in = '0; data_valid_in = 0; psum_in = '0; psum_valid_in = 0;
    weight_in = '0; weight_load = 0; weight_swap = 0; acc_clear = 0; acc_drain = 0;
  endtask

  initial begin
    bit md;
    longint pin;
    int lim;

    zeroInputs();
    resetModel();
    rst_n = 1'b0;
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // WS basic: weight 3, -4 * 3 + 100 = 88
    applyStimulus(0, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    checkOutput("weight_chain_out", longint'(wout_s), 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, -4, 1, 100, 0, 0, 0, 0, 0, 0);
    checkOutput("ws_basic_psum", longint'(psum_s), 88);
    checkOutput("ws_basic_valid", longint'(pv_s), 1);
    checkOutput("ws_basic_data_out", longint'(dout_s), -4);

    // Double buffer: load 5 while streaming with 3 active
    applyStimulus(0, 1, 1, 0, 0, 5, 1, 0, 0, 0);
    checkOutput("dbuf_old_weight", longint'(psum_s), 3);
    applyStimulus(0, 2, 1, 0, 0, 0, 0, 1, 0, 0);
    checkOutput("dbuf_swap_cycle", longint'(psum_s), 6);
    applyStimulus(0, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("dbuf_new_weight", longint'(psum_s), 10);
    checkOutput("dbuf_weight_out", longint'(wout_s), 5);

    // Saturation at the positive limit
    applyStimulus(0, 0, 0, 0, 0, 127, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 127, 1, 524287, 0, 0, 0, 0, 0, 0);
    checkOutput("sat_clamp", longint'(psum_s), 524287);
    checkOutput("sat_overflow", longint'(ovf_s), 1);
    checkOutput("wrap_value", longint'(psum_w), -508160);
    checkOutput("wrap_overflow", longint'(ovf_w), 1);

    // OS accumulate and drain with weight 2; entering OS clears overflow
    applyStimulus(0, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("clear_overflow", longint'(ovf_s), 0);
    checkOutput("clear_overflow_wrap", longint'(ovf_w), 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 4, 1, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("os_drain_value", longint'(psum_s), 20);
    checkOutput("os_drain_valid", longint'(pv_s), 1);
    idle(1);
    checkOutput("os_drain_one_cycle", longint'(pv_s), 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("os_acc_zero_after", longint'(psum_s), 0);

    // Forwarding, then drain/forward collision
    applyStimulus(1, 0, 0, 77, 1, 0, 0, 0, 0, 0);
    checkOutput("os_forward", longint'(psum_s), 77);
    applyStimulus(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 77, 1, 0, 0, 0, 0, 1);
    checkOutput("os_collision_drain_wins", longint'(psum_s), 9);

    // Asynchronous reset in the middle of an accumulation
    applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    resetModel();
    zeroInputs();
    mode = 1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("reset_drain_zero", longint'(psum_s), 0);
    checkOutput("reset_drain_valid", longint'(pv_s), 1);

    // Randomised traffic in fixed-mode chunks with idle cycles at each switch
    for (int c = 0; c < 16; c++) begin
      md = bit'($urandom_range(0, 1));
      idle(md);
      for (int i = 0; i < 24; i++) begin
        lim = $urandom_range(0, 3);
        if (lim == 0)
          pin = ($urandom_range(0, 1) == 1) ? ACC_MAX - longint'($urandom_range(0, 20000))
                                            : ACC_MIN + longint'($urandom_range(0, 20000));
        else
          pin = longint'($urandom_range(0, 1048575)) + ACC_MIN;
        applyStimulus(md,
                      int'($urandom_range(0, 255)) - 128,
                      ($urandom_range(0, 9) < 7),
                      pin,
                      ($urandom_range(0, 9) < 3),
                      int'($urandom_range(0, 255)) - 128,
                      ($urandom_range(0, 4) == 0),
                      ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 19) == 0),
                      ($urandom_range(0, 9) == 0));
      end
      idle(md);
    end

    idle(0);
    idle(0);
    @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", longint'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/configurable_pe.md
# configurable_pe

Parametrised multiply-accumulate processing element for the systolic array, successor to the single-mode PE. It adds separate operand and accumulator widths, double-buffered weights for loading under traffic, selectable saturation, valid tracking, and a runtime mode. The modes are weight-stationary partial-sum pass-through and output-stationary local accumulation with drain. Instances tile into a grid: data flows horizontally, partial sums and weights flow vertically.

## Interface
- DATA_WIDTH, 8, signed operand width of data and weight
- ACC_WIDTH, 20, signed accumulator/partial-sum width; elaboration error unless ACC_WIDTH >= 2*DATA_WIDTH+1
- SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- mode  in  1  0 = WS (weight-stationary), 1 = OS (output-stationary)
- data_in  in  DATA_WIDTH  signed activation from west
- data_valid_in  in  1  data_in qualifier
- data_out  out  DATA_WIDTH  registered activation to east
- data_valid_out  out  1  registered data_valid_in
- psum_in  in  ACC_WIDTH  signed partial sum from north
- psum_valid_in  in  1  psum_in qualifier
- psum_out  out  ACC_WIDTH  registered partial sum/drained result to south
- psum_valid_out  out  1  psum_out qualifier
- weight_in  in  DATA_WIDTH  weight from north chain
- weight_load  in  1  write weight_in into shadow weight
- weight_swap  in  1  copy shadow weight into active weight
- weight_out  out  DATA_WIDTH  shadow weight, feeds south neighbour's weight_in
- acc_clear  in  1  OS: zero accumulator and overflow flag
- acc_drain  in  1  OS: emit accumulator on psum_out
- overflow  out  1  sticky: any saturated/wrapped addition since reset or acc_clear

## Operation
- Product p = data_in * w_active, signed 2*DATA_WIDTH, sign-extended to ACC_WIDTH.
- Adds are evaluated at ACC_WIDTH+1 bits. Out-of-range results set overflow. With SATURATE=1 they clamp to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1); with SATURATE=0 they truncate.
- Weights:
  - weight_load: shadow <= weight_in.
  - weight_swap: active <= shadow.
  - Both asserted in one cycle: active gets the old shadow, shadow gets weight_in.
  - A MAC in a swap cycle uses the old active weight.
- Data path, both modes: data_valid_out <= data_valid_in. data_out <= data_in when valid, otherwise it holds.
- WS mode:
  - data_valid_in=1: psum_out <= sat(psum_in + p), psum_valid_out <= 1.
  - Otherwise: psum_out holds, psum_valid_out <= 0.
  - psum_valid_in is ignored.
  - acc_clear, acc_drain and the accumulator are ignored and held.
- OS mode:
  - acc_next = sat(base + (data_valid_in ? p : 0)), where base = acc_clear ? 0 : acc.
  - acc_drain=1: psum_out <= acc_next, psum_valid_out <= 1, acc <= 0.
  - acc_drain=0: acc <= acc_next. If psum_valid_in=1, psum_out <= psum_in and psum_valid_out <= 1 (forward upstream drain). Otherwise psum_out holds and psum_valid_out <= 0.
  - drain and psum_valid_in in the same cycle: drain wins and the upstream value is dropped. The controller schedules a diagonal drain to avoid this.
- acc_clear also clears overflow; an overflow occurring in the same cycle sets it again.
- Mode changes are legal only while no valid is in flight. A change takes effect at the next edge, and the accumulator is preserved.

## Timing
- Reset: data_out, psum_out, weight_out, both weights, acc = 0; data_valid_out, psum_valid_out, overflow = 0. Reset is immediate and asynchronous, also mid-accumulation. Release is sampled on the next rising edge.
- Latency:
  - One cycle from input to data_out, psum_out and weight_out.
  - A column of N PEs shifts a full weight set in N cycles of weight_load.
  - One weight_swap then switches all PEs simultaneously.
- No backpressure; every output is valid for exactly the cycles flagged.

## Structure
- Shared package pe_pkg:
  - pe_mode_e enum (PE_MODE_WS=1'b0, PE_MODE_OS=1'b1).
  - Saturation bound constants as functions of width.
- Sub-module pe_sat_add: combinational ACC_WIDTH signed adder with SATURATE parameter. Outputs are the sum and an overflow bit. It is instantiated once and muxed between psum_in and the accumulator base.

## Test plan
- WS basic: load 3, swap; data_in=-4 valid, psum_in=100 -> next cycle psum_out=88, psum_valid_out=1, data_out=-4.
- Double buffer: active=3, load 5 while streaming. Swap with data_in=2, psum_in=0 -> psum_out=6. Next data_in=2 -> psum_out=10. weight_out=5 throughout.
- Saturation: psum_in=524287, data_in=127, w=127. SATURATE=1 -> psum_out=524287, overflow=1. SATURATE=0 -> psum_out=-508160, overflow=1. acc_clear -> overflow=0.
- OS accumulate/drain: mode=1, acc_clear, w=2, data 1,2,3,4 with drain in the 4th cycle -> psum_out=20 valid for one cycle; acc=0 after.
- OS forward/collision: psum_valid_in=1, psum_in=77, no drain -> psum_out=77 valid. Same with drain and acc=9 -> psum_out=9, 77 dropped.
- Reset mid-operation: rst_n low during OS accumulation -> all outputs 0 asynchronously. After release, a drain yields psum_out=0.
